// File: rtl/prbs_ber_checker.sv
// PRBS9 bit-error-rate checker: latency search against a local reference, lock, then BER accumulation.
// Optional polarity detection (lock onto an inverted stream) is built when PRBS_CHK_POLARITY_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SEARCH | trying candidate latency lat_q, one window per candidate
// ST_LOCK   | aligned at lat_q; counting bits/errors, watching loss threshold
module prbs_ber_checker #(
   parameter logic [8:0] SEED     = 9'h1AA,
   parameter int         MAX_LAT  = 32,
   parameter int         WINDOW   = 511,
   parameter int         LOSS_THR = 64,
   parameter int         NB_CNT   = 64
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   input  logic                       i_bit,
   input  logic                       i_enable,
   input  logic                       i_clear,
   output logic                       o_locked,
   output logic [$clog2(MAX_LAT)-1:0] o_latency,
   output logic                       o_inverted,
   output logic [NB_CNT-1:0]          o_bit_count,
   output logic [NB_CNT-1:0]          o_err_count
);

   localparam int LW = $clog2(MAX_LAT);
   localparam int WW = $clog2(WINDOW + 1);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCK   = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [8:0]          lfsr_q;
   logic [MAX_LAT-1:0]  dl_q;
   logic [LW-1:0]       lat_q, lat_d;
   logic [WW-1:0]       win_cnt_q, win_cnt_d;
   logic [WW-1:0]       err_win_q, err_win_d;
   logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
   logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
   logic                inv_q;

   logic                ref_bit;
   logic                qual;
   logic                cmp;
   logic [WW-1:0]       err_tot;
   logic                win_last;
   logic                loss_hit;
   logic                all_err;
   logic                pol_lock;

   assign ref_bit  = lfsr_q[8];
   assign qual     = i_valid & i_enable;
   assign cmp      = i_bit ^ dl_q[lat_q] ^ inv_q;
   // Window error total including the current compare, saturating at WINDOW.
   assign err_tot  = (err_win_q == WW'(WINDOW)) ? err_win_q : err_win_q + WW'(cmp);
   assign win_last = (win_cnt_q == WW'(WINDOW - 1));
   assign loss_hit = (32'(err_tot) >= 32'(LOSS_THR));
   assign all_err  = (err_tot == WW'(WINDOW));

`ifdef PRBS_CHK_POLARITY_EN
   logic inv_d;

   assign pol_lock = all_err;

   always_comb begin
      inv_d = inv_q;
      if (qual) begin
         if (state_q == ST_SEARCH && win_last && err_tot != '0 && all_err)
            inv_d = 1'b1;
         else if (state_q == ST_LOCK && loss_hit)
            inv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) inv_q <= 1'b0;
      else       inv_q <= inv_d;
   end
`else
   assign pol_lock = 1'b0;
   assign inv_q    = 1'b0;
`endif

   // Reference and delay line free-run on every strobe so alignment survives i_enable low.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         lfsr_q <= SEED;
         dl_q   <= '0;
      end else if (i_valid) begin
         lfsr_q <= {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
         dl_q   <= {dl_q[MAX_LAT-2:0], ref_bit};
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q   <= ST_SEARCH;
         lat_q     <= '0;
         win_cnt_q <= '0;
         err_win_q <= '0;
         bit_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         win_cnt_q <= win_cnt_d;
         err_win_q <= err_win_d;
         bit_cnt_q <= bit_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (qual) begin
         case (state_q)
            ST_SEARCH: if (win_last && (err_tot == '0 || pol_lock)) state_d = ST_LOCK;
            ST_LOCK:   if (loss_hit) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
         endcase
      end
   end

   always_comb begin
      lat_d     = lat_q;
      win_cnt_d = win_cnt_q;
      err_win_d = err_win_q;
      bit_cnt_d = bit_cnt_q;
      err_cnt_d = err_cnt_q;
      if (qual) begin
         case (state_q)
            ST_SEARCH: begin
               if (win_last) begin
                  win_cnt_d = '0;
                  err_win_d = '0;
                  if (err_tot != '0 && !pol_lock)
                     lat_d = (lat_q == LW'(MAX_LAT - 1)) ? '0 : lat_q + LW'(1);
               end else begin
                  win_cnt_d = win_cnt_q + WW'(1);
                  err_win_d = err_tot;
               end
            end
            ST_LOCK: begin
               if (bit_cnt_q != '1)
                  bit_cnt_d = bit_cnt_q + NB_CNT'(1);
               if (cmp && err_cnt_q != '1)
                  err_cnt_d = err_cnt_q + NB_CNT'(1);
               if (loss_hit || win_last) begin
                  win_cnt_d = '0;
                  err_win_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + WW'(1);
                  err_win_d = err_tot;
               end
            end
            default: ;
         endcase
      end
      if (i_clear) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   assign o_locked    = (state_q == ST_LOCK);
   assign o_latency   = lat_q;
   assign o_inverted  = inv_q;
   assign o_bit_count = bit_cnt_q;
   assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: segment table for search/lock/loss, hand sequences for
// clear, reset mid-lock, polarity (PRBS_CHK_POLARITY_EN) and latency wrap-around.
`timescale 1ns/1ps
module tb_prbs_ber_checker;

   logic        clk = 1'b0;
   logic        i_rst, i_valid, i_bit, i_enable, i_clear;
   logic        o_locked, o_inverted;
   logic [4:0]  o_latency;
   logic [63:0] o_bit_count, o_err_count;

   always #5 clk = ~clk;

   prbs_ber_checker dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_bit       (i_bit),
      .i_enable    (i_enable),
      .i_clear     (i_clear),
      .o_locked    (o_locked),
      .o_latency   (o_latency),
      .o_inverted  (o_inverted),
      .o_bit_count (o_bit_count),
      .o_err_count (o_err_count)
   );

   typedef struct {
      string  name;
      int     nstb;
      int     gap;
      int     lat;
      int     nflip;
      bit     en;
      bit     e_lock;
      int     e_lat;
      longint e_bits;
      longint e_errs;
   } seg_t;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  k       = 0;
   bit  any_lock;
   bit  prbs [511];
   seg_t segs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit stream_bit(input int kk, input int lat, input bit inv);
      if (kk >= lat + 1) return prbs[(kk - 1 - lat) % 511] ^ inv;
      return inv;
   endfunction

   // Entered and left on a negedge; one strobe then `gap` idle cycles.
   task automatic strobe(input bit b, input int gap);
      i_valid = 1'b1;
      i_bit   = b;
      k++;
      @(negedge clk);
      if (o_locked) any_lock = 1'b1;
      i_valid = 1'b0;
      i_bit   = ~b;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send(input int n, input int gap, input int lat, input bit inv,
                       input int nflip, input bit en);
      i_enable = en;
      for (int i = 0; i < n; i++)
         strobe(stream_bit(k, lat, inv) ^ (i < nflip), gap);
      i_enable = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
      repeat (2) @(negedge clk);
      i_rst = 1'b0;
      k = 0;
      any_lock = 1'b0;
   endtask

   task automatic chk_all(input string name, input bit lk, input int lat, input bit inv,
                          input longint bits, input longint errs);
      chk({name, ".locked"},   64'(o_locked),   64'(lk));
      chk({name, ".latency"},  64'(o_latency),  64'(lat));
      chk({name, ".inverted"}, 64'(o_inverted), 64'(inv));
      chk({name, ".bits"},     o_bit_count,     64'(bits));
      chk({name, ".errs"},     o_err_count,     64'(errs));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] lf;
      lf = 9'h1AA;
      for (int i = 0; i < 511; i++) begin
         prbs[i] = lf[8];
         lf = {lf[7:0], lf[8] ^ lf[4]};
      end

      segs[0] = '{"search",   3065, 3, 5,  0, 1'b1, 1'b0, 5,   0,  0};
      segs[1] = '{"lockstb",     1, 3, 5,  0, 1'b1, 1'b1, 5,   0,  0};
      segs[2] = '{"clean",     100, 3, 5,  0, 1'b1, 1'b1, 5, 100,  0};
      segs[3] = '{"flip63",     63, 3, 5, 63, 1'b1, 1'b1, 5, 163, 63};
      segs[4] = '{"flip64",      1, 3, 5,  1, 1'b1, 1'b0, 5, 164, 64};
      segs[5] = '{"relock_pre", 510, 3, 5, 0, 1'b1, 1'b0, 5, 164, 64};
      segs[6] = '{"relock",      1, 3, 5,  0, 1'b1, 1'b1, 5, 164, 64};
      segs[7] = '{"disabled",   10, 3, 5, 10, 1'b0, 1'b1, 5, 164, 64};
      segs[8] = '{"reenable",   20, 3, 5,  0, 1'b1, 1'b1, 5, 184, 64};

      i_rst = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_enable = 1'b1; i_clear = 1'b0;
      do_reset();
      chk_all("reset", 1'b0, 0, 1'b0, 0, 0);

      for (int i = 0; i < 100; i++) begin
         i_bit = i[0];
         @(negedge clk);
      end
      chk_all("idle", 1'b0, 0, 1'b0, 0, 0);

      for (int s = 0; s < 9; s++) begin
         send(segs[s].nstb, segs[s].gap, segs[s].lat, 1'b0, segs[s].nflip, segs[s].en);
         chk_all(segs[s].name, segs[s].e_lock, segs[s].e_lat, 1'b0, segs[s].e_bits, segs[s].e_errs);
      end

      // Clear wins over a simultaneous error increment.
      i_clear = 1'b1;
      strobe(stream_bit(k, 5, 1'b0) ^ 1'b1, 0);
      i_clear = 1'b0;
      chk_all("clear_err", 1'b1, 5, 1'b0, 0, 0);
      send(1, 0, 5, 1'b0, 0, 1'b1);
      chk_all("after_clear", 1'b1, 5, 1'b0, 1, 0);
      send(1, 0, 5, 1'b0, 1, 1'b1);
      chk_all("err_after_clear", 1'b1, 5, 1'b0, 2, 1);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      chk_all("clear_idle", 1'b1, 5, 1'b0, 0, 0);

      // Reset mid-lock, with a strobe present, then relock at a new latency from the reseeded reference.
      i_rst = 1'b1; i_valid = 1'b1; i_bit = 1'b1;
      @(negedge clk);
      i_rst = 1'b0; i_valid = 1'b0;
      k = 0;
      chk_all("rst_midlock", 1'b0, 0, 1'b0, 0, 0);
      send(3 * 511 - 1, 0, 2, 1'b0, 0, 1'b1);
      chk_all("lat2_pre", 1'b0, 2, 1'b0, 0, 0);
      send(1, 0, 2, 1'b0, 0, 1'b1);
      chk_all("lat2_lock", 1'b1, 2, 1'b0, 0, 0);

      // Inverted stream at latency 3.
      do_reset();
      send(4 * 511 - 1, 0, 3, 1'b1, 0, 1'b1);
      chk_all("inv_pre", 1'b0, 3, 1'b0, 0, 0);
      send(1, 0, 3, 1'b1, 0, 1'b1);
`ifdef PRBS_CHK_POLARITY_EN
      chk_all("inv_lock", 1'b1, 3, 1'b1, 0, 0);
      send(50, 0, 3, 1'b1, 0, 1'b1);
      chk_all("inv_run", 1'b1, 3, 1'b1, 50, 0);
`else
      chk_all("inv_nolock", 1'b0, 4, 1'b0, 0, 0);
      send(4 * 511, 0, 3, 1'b1, 0, 1'b1);
      chk_all("inv_search", 1'b0, 8, 1'b0, 0, 0);
      chk("inv_never_locked", 64'(any_lock), 64'd0);
`endif

      // Unrelated constant-zero stream: latency walks 0..31 and wraps.
      do_reset();
      i_enable = 1'b1;
      for (int w = 0; w < 32; w++) begin
         for (int i = 0; i < 511; i++) strobe(1'b0, 0);
         chk($sformatf("wrap.lat%0d", w), 64'(o_latency), 64'((w + 1) % 32));
      end
      chk("wrap.never_locked", 64'(any_lock), 64'd0);
      chk_all("wrap_end", 1'b0, 0, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
